// File: rtl/rot_share_ctrl.sv
// rot_share_ctrl: round-robin arbiter that time-shares an external 4-bit right-rotate datapath between two requesters
// Ports: clk/rst_n (async active-low reset); req0_*/req1_* valid/ready request ports carrying a 4-bit word and AMT_W-bit
// rotate amount; sh_in/sh_k drive the shared shifter, sh_out is its combinational result; res_* valid/ready result port.
// Optional macro ROT_MOD_REDUCE_EN: latch only amt mod 4 so every request finishes in a single pass.
module rot_share_ctrl #(
  parameter int AMT_W = 4,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic [3:0]       sh_in,
  output logic [1:0]       sh_k,
  input  logic [3:0]       sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_id
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] work;
  logic [AMT_W-1:0] rem, rem_nx, amt_acc;
  logic id, ptr, g0, g1, acc;
  logic [1:0] k;
  assign g0 = req0_valid && (!req1_valid || !ptr);
  assign g1 = req1_valid && (!req0_valid || ptr);
  assign acc = state == IDLE && (g0 || g1);
  // Cap each pass at 3 positions; k never exceeds rem, so rem cannot underflow.
  assign k = (rem >= AMT_W'(3)) ? 2'd3 : rem[1:0];
  assign rem_nx = rem - AMT_W'(k);
`ifdef ROT_MOD_REDUCE_EN
  assign amt_acc = AMT_W'(g0 ? req0_amt[1:0] : req1_amt[1:0]);
`else
  assign amt_acc = g0 ? req0_amt : req1_amt;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      rem <= '0;
      id <= 1'b0;
      ptr <= 1'(PRIO_INIT);
    end else begin
      state <= state_nx;
      if (acc) begin
        work <= g0 ? req0_data : req1_data;
        rem <= amt_acc;
        id <= !g0;
        ptr <= g0;
      end else if (state == RUN) begin
        work <= sh_out;
        rem <= rem_nx;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (acc ? RUN : IDLE) :
               state == RUN  ? (rem_nx == '0 ? DONE : RUN) :
               (res_ready ? IDLE : DONE);
  end
  // Readies are gated by rst_n so they read 0 while reset is held, even with a request pending.
  always_comb begin
    req0_ready = rst_n && state == IDLE && g0;
    req1_ready = rst_n && state == IDLE && g1;
    sh_in = state == RUN ? work : 4'd0;
    sh_k = state == RUN ? k : 2'd0;
    res_valid = state == DONE;
    res_data = state == DONE ? work : 4'd0;
    res_id = state == DONE && id;
  end
endmodule

// File: tb/tb_rot_share_ctrl.sv
// tb_rot_share_ctrl: randomized scoreboard bench for rot_share_ctrl with a behavioural rotate/arbitration model
module tb_rot_share_ctrl;
  localparam int AMT_W = 4;
  localparam int PRIO_INIT = 0;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, res_ready = 0;
  logic req0_ready, req1_ready, res_valid, res_id;
  logic [3:0] req0_data = 0, req1_data = 0, sh_in, sh_out, res_data;
  logic [AMT_W-1:0] req0_amt = 0, req1_amt = 0;
  logic [1:0] sh_k;
  int tests = 0, fails = 0, cyc = 0;
  bit rr_hold = 0;
  typedef struct {logic [3:0] data; logic id; int lat; int acc;} exp_t;
  exp_t q[$];
  bit busy = 0, ptr = 1'(PRIO_INIT), prev_hold = 0, hid, e0, e1;
  logic [3:0] hd;

  rot_share_ctrl #(.AMT_W(AMT_W), .PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
    .sh_in(sh_in), .sh_k(sh_k), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rotr(logic [3:0] d, int n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = d[(i + n) % 4];
    return r;
  endfunction

  assign sh_out = rotr(sh_in, int'(sh_k));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(logic [3:0] d, int amt, logic n);
    exp_t e;
    int passes;
`ifdef ROT_MOD_REDUCE_EN
    passes = 1;
`else
    passes = amt == 0 ? 1 : (amt + 2) / 3;
`endif
    e.data = rotr(d, amt % 4);
    e.id = n;
    e.lat = passes + 1;
    e.acc = cyc;
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      busy = 0;
      ptr = 1'(PRIO_INIT);
      prev_hold = 0;
      chk("reset_outputs", {res_valid, res_data, res_id, req0_ready, req1_ready, sh_in, sh_k}, 0);
    end else begin
      e0 = !busy && req0_valid && (!req1_valid || !ptr);
      e1 = !busy && req1_valid && (!req0_valid || ptr);
      if (req0_valid || req1_valid || req0_ready || req1_ready)
        chk("grant", {req1_ready, req0_ready}, {e1, e0});
      if (q.size() == 0) chk("spurious_res_valid", res_valid, 0);
      if (prev_hold) chk("hold_stable", {res_valid, res_data, res_id}, {1'b1, hd, hid});
      if (res_valid && !prev_hold && q.size() > 0) chk("latency", cyc - q[0].acc, q[0].lat);
      if (res_valid && res_ready && q.size() > 0) begin
        chk("res_data", res_data, q[0].data);
        chk("res_id", res_id, q[0].id);
        void'(q.pop_front());
        busy = 0;
      end
      prev_hold = res_valid && !res_ready;
      hd = res_data;
      hid = res_id;
      if (e0) begin
        q.push_back(model(req0_data, int'(req0_amt), 1'b0));
        ptr = 1;
        busy = 1;
      end else if (e1) begin
        q.push_back(model(req1_data, int'(req1_amt), 1'b1));
        ptr = 0;
        busy = 1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1 res_ready = !rr_hold && ($urandom_range(0, 3) != 0);
  end

  task automatic issue(bit v0, logic [3:0] d0, int a0, bit v1, logic [3:0] d1, int a1);
    bit s0, s1;
    req0_valid = v0; req0_data = d0; req0_amt = AMT_W'(a0);
    req1_valid = v1; req1_data = d1; req1_amt = AMT_W'(a1);
    for (int t = 0; t < 300 && (req0_valid || req1_valid); t++) begin
      @(negedge clk);
      s0 = req0_valid && req0_ready;
      s1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (s0) req0_valid = 0;
      if (s1) req1_valid = 0;
    end
    chk("accept_timeout", {req0_valid, req1_valid}, 0);
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 300 && (busy || q.size() > 0); t++) begin
      @(negedge clk);
      #2;
    end
    chk("drain_timeout", {busy, q.size() != 0}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    issue(1, 4'b1011, 7, 0, 4'b0, 0);
    wait_idle();
    issue(1, 4'b0001, 1, 1, 4'b1000, 2);
    issue(1, 4'b0101, 2, 1, 4'b0011, 3);
    wait_idle();
    issue(0, 4'b0, 0, 1, 4'b0110, 0);
    wait_idle();
    rr_hold = 1;
    issue(1, 4'($urandom), 5, 0, 4'b0, 0);
    fork
      issue(0, 4'b0, 0, 1, 4'($urandom), 4);
      begin
        for (int t = 0; t < 50 && !res_valid; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1 rr_hold = 0;
      end
    join
    wait_idle();
    req0_valid = 1; req0_data = 4'b1001; req0_amt = AMT_W'(15);
    for (int t = 0; t < 50 && !req0_ready; t++) @(negedge clk);
    @(posedge clk);
    #1 req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("async_reset_outputs", {res_valid, res_data, res_id, req0_ready, req1_ready, sh_in, sh_k}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (20) @(posedge clk);
    #1;
    issue(1, 4'($urandom), 3, 1, 4'($urandom), 6);
    wait_idle();
    for (int a = 0; a < (1 << AMT_W); a++) begin
      if ($urandom_range(0, 1) == 1) issue(1, 4'($urandom), a, 0, 4'b0, 0);
      else issue(0, 4'b0, 0, 1, 4'($urandom), a);
    end
    for (int i = 0; i < 60; i++) begin
      int m;
      m = $urandom_range(1, 3);
      issue(m[0], 4'($urandom), $urandom_range(0, (1 << AMT_W) - 1),
            m[1], 4'($urandom), $urandom_range(0, (1 << AMT_W) - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
